// File: rtl/rom_dn_loader.sv
// ROM download front end: forwards ioctl bytes to the core ROM port, checks image size and ordering, and holds the core in reset until the image is verified.
// Forwarded bytes appear one cycle after the strobe. core_hold drops RELEASE_CYCLES+1 cycles after download falls.
module rom_dn_loader #(
    parameter int PROG_BYTES     = 6144,
    parameter int VROM_BYTES     = 2048,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ioctl_download,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    output logic [15:0] o_dn_addr,
    output logic [7:0]  o_dn_data,
    output logic        o_dn_wr,
    output logic        o_prog_cs,
    output logic        o_vrom_cs,
    output logic        o_core_hold,
    output logic        o_load_done,
    output logic        o_load_error,
    output logic [15:0] o_byte_count,
    output logic [15:0] o_checksum
);

    localparam int IMG_BYTES = PROG_BYTES + VROM_BYTES;
    localparam int CW        = $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_RELEASE, S_DONE, S_ERROR
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_dl_q;
    logic           r_seq_err;
    logic [CW-1:0]  r_rel_cnt;

    logic w_dl_rise;
    logic w_dl_fall;
    logic w_accept;
    logic w_in_prog;
    logic w_in_vrom;
    logic w_pass;

    assign w_dl_rise = i_ioctl_download & ~r_dl_q;
    assign w_dl_fall = ~i_ioctl_download & r_dl_q;
    assign w_accept  = (r_state == S_LOAD) & i_ioctl_wr & i_ioctl_download;
    assign w_in_prog = i_ioctl_addr < 25'(PROG_BYTES);
    assign w_in_vrom = !w_in_prog && (i_ioctl_addr < 25'(IMG_BYTES));
    assign w_pass    = (o_byte_count == 16'(IMG_BYTES)) && !r_seq_err;

    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // A fresh download rise wins from every state, so a reload can abort RELEASE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:    if (w_dl_fall) w_next = S_CHECK;
            S_CHECK:   w_next = w_pass ? S_RELEASE : S_ERROR;
            S_RELEASE: if (r_rel_cnt == '0) w_next = S_DONE;
            S_IDLE, S_DONE, S_ERROR: w_next = r_state;
            default:   w_next = S_IDLE;
        endcase
        if (w_dl_rise) w_next = S_LOAD;
    end

    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_dl_q       <= 1'b0;
            r_seq_err    <= 1'b0;
            r_rel_cnt    <= '0;
            o_dn_addr    <= '0;
            o_dn_data    <= '0;
            o_dn_wr      <= 1'b0;
            o_prog_cs    <= 1'b0;
            o_vrom_cs    <= 1'b0;
            o_core_hold  <= 1'b1;
            o_load_done  <= 1'b0;
            o_load_error <= 1'b0;
            o_byte_count <= '0;
            o_checksum   <= '0;
        end else begin
            r_dl_q    <= i_ioctl_download;
            o_dn_wr   <= w_accept;
            o_prog_cs <= w_accept & w_in_prog;
            o_vrom_cs <= w_accept & w_in_vrom;

            if (w_accept) begin
                o_dn_addr  <= i_ioctl_addr[15:0];
                o_dn_data  <= i_ioctl_dout;
                o_checksum <= o_checksum + {8'd0, i_ioctl_dout};
                if (o_byte_count != 16'hFFFF)
                    o_byte_count <= o_byte_count + 16'd1;
                // Out-of-order and out-of-image bytes both poison the image.
                if ((i_ioctl_addr != {9'd0, o_byte_count}) || !(w_in_prog || w_in_vrom))
                    r_seq_err <= 1'b1;
            end

            if (r_state == S_CHECK && w_next == S_RELEASE)
                r_rel_cnt <= CW'(RELEASE_CYCLES - 1);
            else if (r_state == S_RELEASE && r_rel_cnt != '0)
                r_rel_cnt <= r_rel_cnt - 1'b1;

            if (r_state == S_CHECK && w_next == S_ERROR)
                o_load_error <= 1'b1;

            if (r_state == S_RELEASE && w_next == S_DONE) begin
                o_core_hold <= 1'b0;
                o_load_done <= 1'b1;
            end

            if (w_dl_rise) begin
                o_byte_count <= '0;
                o_checksum   <= '0;
                r_seq_err    <= 1'b0;
                o_load_done  <= 1'b0;
                o_load_error <= 1'b0;
                o_core_hold  <= 1'b1;
            end
        end
    end

endmodule
